// File: rtl/vectored_int_pkg.sv
// Shared types and helpers for the vectored interrupt controller.
package vectored_int_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } state_t;

  localparam logic [31:0] VEC_BASE_DEFAULT = 32'hFFFF_FFFC;

  // Highest set bit of a (zero-extended) source vector; returns 0 when empty.
  function automatic logic [4:0] highest_set_idx(input logic [31:0] vec);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (vec[i]) begin
        idx = i[4:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/vectored_int_prio_enc.sv
// Fixed-priority encoder: highest-numbered request wins.
module vectored_int_prio_enc
  import vectored_int_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any_set
);

  logic [31:0] req_ext_s;
  logic [4:0]  idx_full_s;

  // Zero-extend to the helper's fixed width and trim the result back.
  always_comb begin
    req_ext_s  = 32'(req);
    idx_full_s = highest_set_idx(req_ext_s);
    idx        = IW'(idx_full_s);
    any_set    = |req;
  end

endmodule

// File: rtl/vectored_int_ctrl.sv
// Vectored interrupt controller: latches done events, masks, prioritises and serves one vector per ack.
// Define VECTORED_INT_LEVEL_EN for level-sensitive sources (no pending latch, no edge detect).
module vectored_int_ctrl
  import vectored_int_pkg::*;
#(
  parameter int          NUM_SRC  = 4,
  parameter int          IDX_W    = $clog2(NUM_SRC),
  parameter logic [31:0] VEC_BASE = VEC_BASE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] done,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               int_ack,
  output logic               int_req,
  output logic               int_valid,
  output logic [31:0]        int_addr,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask
);

  logic [NUM_SRC-1:0] mask_r;
  logic [NUM_SRC-1:0] eligible_s;
  logic [IDX_W-1:0]   win_idx_s;
  logic               win_any_s;
  logic               capture_s;
  state_t             state_r, state_n_s;
  logic [IDX_W-1:0]   vec_idx_r, vec_idx_n_s;
  logic               int_req_r, int_req_n_s;
  logic               int_valid_r, int_valid_n_s;
  logic [31:0]        int_addr_r, int_addr_n_s;

  assign capture_s = (state_r == ST_IDLE) && int_ack && win_any_s;

`ifdef VECTORED_INT_LEVEL_EN
  assign eligible_s = done & mask_r;
  assign pending    = done;
`else
  logic [NUM_SRC-1:0] pending_r, done_q_r, rise_s, clr_s;

  assign rise_s     = done & ~done_q_r;
  assign clr_s      = capture_s ? (NUM_SRC'(1) << win_idx_s) : '0;
  assign eligible_s = pending_r & mask_r;
  assign pending    = pending_r;

  // Edge detector and pending latch; a new rise beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q_r  <= '0;
      pending_r <= '0;
    end else begin
      done_q_r  <= done;
      pending_r <= (pending_r & ~clr_s) | rise_s;
    end
  end
`endif

  vectored_int_prio_enc #(
    .N  (NUM_SRC),
    .IW (IDX_W)
  ) u_prio_enc (
    .req     (eligible_s),
    .idx     (win_idx_s),
    .any_set (win_any_s)
  );

  // Mask register and FSM/output state.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask_r      <= '1;
      state_r     <= ST_IDLE;
      vec_idx_r   <= '0;
      int_req_r   <= 1'b0;
      int_valid_r <= 1'b0;
      int_addr_r  <= VEC_BASE;
    end else begin
      mask_r      <= mask_we ? mask_wdata : mask_r;
      state_r     <= state_n_s;
      vec_idx_r   <= vec_idx_n_s;
      int_req_r   <= int_req_n_s;
      int_valid_r <= int_valid_n_s;
      int_addr_r  <= int_addr_n_s;
    end
  end

  // Next-state and registered-output logic; int_addr holds its last vector outside capture.
  always_comb begin
    state_n_s     = state_r;
    vec_idx_n_s   = vec_idx_r;
    int_req_n_s   = 1'b0;
    int_valid_n_s = int_valid_r;
    int_addr_n_s  = int_addr_r;
    case (state_r)
      ST_IDLE: begin
        if (capture_s) begin
          state_n_s     = ST_SERVICE;
          vec_idx_n_s   = win_idx_s;
          int_valid_n_s = 1'b1;
          int_addr_n_s  = VEC_BASE | 32'(win_idx_s);
        end else begin
          int_req_n_s   = win_any_s;
          int_valid_n_s = 1'b0;
        end
      end
      ST_SERVICE: begin
        if (!int_ack) begin
          state_n_s     = ST_IDLE;
          int_valid_n_s = 1'b0;
        end else begin
          int_valid_n_s = 1'b1;
        end
      end
      default: begin
        state_n_s     = ST_IDLE;
        int_valid_n_s = 1'b0;
      end
    endcase
  end

  assign int_req   = int_req_r;
  assign int_valid = int_valid_r;
  assign int_addr  = int_addr_r;
  assign mask      = mask_r;

endmodule

// File: tb/tb_vectored_int_ctrl.sv
// Directed self-checking bench for vectored_int_ctrl (default edge-latched build).
module tb_vectored_int_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  done;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        int_ack;
  logic        int_req;
  logic        int_valid;
  logic [31:0] int_addr;
  logic [3:0]  pending;
  logic [3:0]  mask;

  int errors = 0;
  int checks = 0;

  vectored_int_ctrl #(
    .NUM_SRC  (4),
    .IDX_W    (2),
    .VEC_BASE (32'hFFFF_FFFC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .done       (done),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_ack    (int_ack),
    .int_req    (int_req),
    .int_valid  (int_valid),
    .int_addr   (int_addr),
    .pending    (pending),
    .mask       (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; done = 4'b0000; mask_we = 1'b0; mask_wdata = 4'b0000; int_ack = 1'b0;
    tick(); tick();
    chk("rst_req",   32'(int_req),   32'h0);
    chk("rst_valid", 32'(int_valid), 32'h0);
    chk("rst_addr",  int_addr,       32'hFFFF_FFFC);
    chk("rst_pend",  32'(pending),   32'h0);
    chk("rst_mask",  32'(mask),      32'hF);
    rst = 1'b0;
    tick();

    // Single pulse on source 2
    done = 4'b0100; tick();
    chk("t1_pend1", 32'(pending), 32'h4);
    chk("t1_req1",  32'(int_req), 32'h0);
    done = 4'b0000; tick();
    chk("t1_req2",  32'(int_req), 32'h1);
    int_ack = 1'b1; tick();
    chk("t1_addr",  int_addr,       32'hFFFF_FFFE);
    chk("t1_valid", 32'(int_valid), 32'h1);
    chk("t1_pend2", 32'(pending),   32'h0);
    chk("t1_req3",  32'(int_req),   32'h0);
    int_ack = 1'b0; tick();
    chk("t1_valid0", 32'(int_valid), 32'h0);
    chk("t1_hold",   int_addr,       32'hFFFF_FFFE);

    // Two simultaneous rises served in priority order
    done = 4'b1001; tick();
    chk("t2_pend", 32'(pending), 32'h9);
    done = 4'b0000; tick();
    chk("t2_req", 32'(int_req), 32'h1);
    int_ack = 1'b1; tick();
    chk("t2_addr1", int_addr,     32'hFFFF_FFFF);
    chk("t2_pend1", 32'(pending), 32'h1);
    int_ack = 1'b0; tick(); tick();
    chk("t2_req2", 32'(int_req), 32'h1);
    int_ack = 1'b1; tick();
    chk("t2_addr2", int_addr, 32'hFFFF_FFFC);
    int_ack = 1'b0; tick(); tick();
    chk("t2_req0",  32'(int_req), 32'h0);
    chk("t2_pend0", 32'(pending), 32'h0);

    // Ack with nothing eligible is ignored
    int_ack = 1'b1; tick();
    chk("t2b_valid", 32'(int_valid), 32'h0);
    chk("t2b_addr",  int_addr,       32'hFFFF_FFFC);
    int_ack = 1'b0; tick();

    // Masked source stays pending until unmasked
    mask_we = 1'b1; mask_wdata = 4'b0111; tick();
    chk("t3_mask", 32'(mask), 32'h7);
    mask_we = 1'b0; done = 4'b1000; tick();
    chk("t3_pend", 32'(pending), 32'h8);
    done = 4'b0000; tick(); tick();
    chk("t3_req0", 32'(int_req), 32'h0);
    mask_we = 1'b1; mask_wdata = 4'b1111; tick();
    mask_we = 1'b0; tick();
    chk("t3_req1", 32'(int_req), 32'h1);
    int_ack = 1'b1; tick();
    chk("t3_addr", int_addr, 32'hFFFF_FFFF);
    int_ack = 1'b0; tick();

    // New event on the source being serviced
    done = 4'b0010; tick();
    done = 4'b0000; tick();
    int_ack = 1'b1; tick();
    chk("t4_addr", int_addr, 32'hFFFF_FFFD);
    done = 4'b0010; tick();
    chk("t4_pend",  32'(pending),   32'h2);
    chk("t4_addr2", int_addr,       32'hFFFF_FFFD);
    chk("t4_valid", 32'(int_valid), 32'h1);
    chk("t4_req0",  32'(int_req),   32'h0);
    done = 4'b0000; int_ack = 1'b0; tick(); tick();
    chk("t4_req1", 32'(int_req), 32'h1);
    int_ack = 1'b1; tick();
    int_ack = 1'b0; tick();

    // Same-cycle clear (capture) and set (new rise): set wins
    done = 4'b0010; tick();
    done = 4'b0000; tick();
    int_ack = 1'b1; done = 4'b0010; tick();
    chk("t4b_pend", 32'(pending), 32'h2);
    chk("t4b_addr", int_addr,     32'hFFFF_FFFD);
    int_ack = 1'b0; done = 4'b0000; tick(); tick();
    chk("t4b_req", 32'(int_req), 32'h1);
    int_ack = 1'b1; tick();
    int_ack = 1'b0; tick();

    // A held line latches only once
    done = 4'b0001; tick(); tick();
    int_ack = 1'b1; tick();
    chk("t5_addr", int_addr, 32'hFFFF_FFFC);
    int_ack = 1'b0; tick(); tick();
    chk("t5_pend", 32'(pending), 32'h0);
    chk("t5_req",  32'(int_req), 32'h0);
    done = 4'b0000; tick();

    // Reset while in service with events pending
    done = 4'b1110; tick();
    done = 4'b0000; tick();
    int_ack = 1'b1; tick();
    chk("t6_pend", 32'(pending), 32'h6);
    mask_we = 1'b1; mask_wdata = 4'b0001; tick();
    mask_we = 1'b0; rst = 1'b1; tick();
    chk("t6_req",   32'(int_req),   32'h0);
    chk("t6_valid", 32'(int_valid), 32'h0);
    chk("t6_addr",  int_addr,       32'hFFFF_FFFC);
    chk("t6_pend0", 32'(pending),   32'h0);
    chk("t6_mask",  32'(mask),      32'hF);
    rst = 1'b0; int_ack = 1'b0; tick(); tick();
    chk("t6_req2", 32'(int_req), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
